clock_ratio_meter: RTL and testbench

CLOCK_RATIO_METER -- requirements
Module: clock_ratio_meter

---
 rtl/clock_ratio_meter.sv | 132 +++++++++++++
 tb/tb_clock_ratio_meter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_ratio_meter.sv
// Measures the period and high time of a slow signal in clk cycles, and flags
// lock (a run of identical periods) and timeout (no rising edge seen for too long).
module clock_ratio_meter #(
  parameter int WIDTH      = 16,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  localparam int LW = $clog2(LOCK_COUNT + 1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  state_t           state;
  state_t           state_next;
  logic             s1;
  logic             s2;
  logic             s3;
  logic             rise;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] hcnt;
  logic [LW-1:0]    lcnt;
  logic [LW-1:0]    lcnt_next;
  logic             capture;
  logic             restart;
  logic             saturate;
  logic             clear_cnt;

  // Two synchronizer flops, then a history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // A falling edge needs no action: hcnt simply stops because s2 is low.
  assign rise = s2 & ~s3;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = ARM;
      ARM:     if (rise) state_next = MEASURE;
      MEASURE: if (!rise && cnt == CNT_MAX) state_next = ARM;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    capture   = 1'b0;
    restart   = 1'b0;
    saturate  = 1'b0;
    clear_cnt = 1'b0;
    case (state)
      IDLE: clear_cnt = 1'b1;
      ARM: begin
        restart  = rise;
        saturate = !rise && cnt == CNT_MAX;
      end
      MEASURE: begin
        capture  = rise;
        restart  = rise;
        saturate = !rise && cnt == CNT_MAX;
      end
      default: clear_cnt = 1'b1;
    endcase
  end

  always_comb begin
    lcnt_next = LW'(1);
    if (cnt == period) begin
      lcnt_next = (lcnt == LW'(LOCK_COUNT)) ? lcnt : lcnt + LW'(1);
    end
  end

  // Counters restart at 1 on a rise because the rise cycle itself belongs to the new period.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      hcnt      <= '0;
      lcnt      <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      valid <= capture;
      if (clear_cnt || saturate) begin
        cnt  <= '0;
        hcnt <= '0;
      end else if (restart) begin
        cnt  <= WIDTH'(1);
        hcnt <= WIDTH'(1);
      end else begin
        cnt  <= cnt + WIDTH'(1);
        hcnt <= hcnt + {{(WIDTH-1){1'b0}}, s2};
      end
      if (capture) begin
        period    <= cnt;
        high_time <= hcnt;
        lcnt      <= lcnt_next;
        locked    <= (lcnt_next == LW'(LOCK_COUNT));
        timeout   <= 1'b0;
      end else if (saturate) begin
        lcnt    <= '0;
        locked  <= 1'b0;
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clock_ratio_meter.sv
// Directed bench for clock_ratio_meter (WIDTH=8 so the timeout is reachable quickly).
module tb_clock_ratio_meter;

  localparam int WIDTH      = 8;
  localparam int LOCK_COUNT = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             sig_in;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             valid;
  logic             locked;
  logic             timeout;

  int n_checks = 0;
  int n_fails  = 0;

  int obs_per[$];
  int obs_hi[$];
  int obs_lk[$];
  int obs_to[$];
  int exp_per[$];
  int exp_hi[$];
  int exp_lk[$];
  int exp_to[$];

  clock_ratio_meter #(.WIDTH(WIDTH), .LOCK_COUNT(LOCK_COUNT)) dut (
    .clk       (clk),
    .rst       (rst),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .locked    (locked),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Record every valid pulse, sampled away from the active edge.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      obs_per.push_back(int'(period));
      obs_hi.push_back(int'(high_time));
      obs_lk.push_back(int'(locked));
      obs_to.push_back(int'(timeout));
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic level, input int cycles);
    sig_in = level;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic wave(input int h, input int l, input int n);
    repeat (n) begin
      apply_stimulus(1'b1, h);
      apply_stimulus(1'b0, l);
    end
  endtask

  task automatic clear_obs();
    obs_per.delete();
    obs_hi.delete();
    obs_lk.delete();
    obs_to.delete();
  endtask

  task automatic do_reset(input int cycles);
    rst    = 1'b1;
    sig_in = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    clear_obs();
  endtask

  task automatic expect_valid(input int p, input int h, input int lk, input int to);
    exp_per.push_back(p);
    exp_hi.push_back(h);
    exp_lk.push_back(lk);
    exp_to.push_back(to);
  endtask

  task automatic check_output(input string tag);
    check({tag, " valid count"}, obs_per.size(), exp_per.size());
    for (int i = 0; i < obs_per.size() && i < exp_per.size(); i++) begin
      check($sformatf("%s[%0d] period", tag, i), obs_per[i], exp_per[i]);
      check($sformatf("%s[%0d] high_time", tag, i), obs_hi[i], exp_hi[i]);
      check($sformatf("%s[%0d] locked", tag, i), obs_lk[i], exp_lk[i]);
      check($sformatf("%s[%0d] timeout", tag, i), obs_to[i], exp_to[i]);
    end
    exp_per.delete();
    exp_hi.delete();
    exp_lk.delete();
    exp_to.delete();
    clear_obs();
  endtask

  initial begin
    rst    = 1'b1;
    sig_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset period", period, 0);
    check("reset high_time", high_time, 0);
    check("reset valid", valid, 0);
    check("reset locked", locked, 0);
    check("reset timeout", timeout, 0);

    $display("[TB] divide-by-4 lock");
    do_reset(2);
    wave(2, 2, 6);
    apply_stimulus(1'b0, 4);
    for (int i = 0; i < 5; i++) expect_valid(4, 2, (i >= 3) ? 1 : 0, 0);
    check_output("div4");

    $display("[TB] divide-by-5 then divide-by-4");
    do_reset(2);
    repeat (5) begin
      apply_stimulus(1'b0, 2);
      apply_stimulus(1'b1, 3);
    end
    repeat (6) begin
      apply_stimulus(1'b0, 2);
      apply_stimulus(1'b1, 2);
    end
    apply_stimulus(1'b0, 4);
    expect_valid(5, 3, 0, 0);
    expect_valid(5, 3, 0, 0);
    expect_valid(5, 3, 0, 0);
    expect_valid(5, 3, 1, 0);
    expect_valid(5, 3, 1, 0);
    expect_valid(4, 2, 0, 0);
    expect_valid(4, 2, 0, 0);
    expect_valid(4, 2, 0, 0);
    expect_valid(4, 2, 1, 0);
    expect_valid(4, 2, 1, 0);
    check_output("div5to4");

    $display("[TB] timeout on stuck-low input");
    do_reset(2);
    wave(2, 2, 6);
    apply_stimulus(1'b0, 300);
    for (int i = 0; i < 5; i++) expect_valid(4, 2, (i >= 3) ? 1 : 0, 0);
    check_output("pre-timeout");
    check("timeout set", timeout, 1);
    check("timeout locked", locked, 0);
    check("timeout period held", period, 4);
    check("timeout high_time held", high_time, 2);
    wave(2, 2, 1);
    check("timeout after first rise", timeout, 1);
    check("no valid on first rise", obs_per.size(), 0);
    wave(2, 2, 3);
    apply_stimulus(1'b0, 4);
    for (int i = 0; i < 3; i++) expect_valid(4, 2, 0, 0);
    check_output("restart");

    $display("[TB] reset mid-period while locked");
    do_reset(2);
    wave(2, 2, 6);
    apply_stimulus(1'b1, 1);
    check("locked before reset", locked, 1);
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    sig_in = 1'b0;
    check("mid reset period", period, 0);
    check("mid reset high_time", high_time, 0);
    check("mid reset valid", valid, 0);
    check("mid reset locked", locked, 0);
    check("mid reset timeout", timeout, 0);
    clear_obs();
    apply_stimulus(1'b0, 1);
    wave(2, 2, 1);
    check("post reset first rise", obs_per.size(), 0);
    wave(2, 2, 1);
    apply_stimulus(1'b0, 4);
    expect_valid(4, 2, 0, 0);
    check_output("post reset");

    $display("[TB] rise right after reset release");
    do_reset(2);
    apply_stimulus(1'b0, 1);
    sig_in = 1'b1;
    @(negedge clk);
    check("rise latency t+1", dut.rise, 0);
    @(negedge clk);
    check("rise latency t+2", dut.rise, 1);
    @(negedge clk);
    check("rise latency t+3", dut.rise, 0);
    apply_stimulus(1'b1, 2);
    apply_stimulus(1'b0, 2);
    apply_stimulus(1'b1, 2);
    apply_stimulus(1'b0, 4);
    expect_valid(7, 5, 0, 0);
    check_output("early rise");

    $display("[TB] duty sweep at period 10");
    do_reset(2);
    for (int h = 1; h <= 9; h++) begin
      apply_stimulus(1'b1, h);
      apply_stimulus(1'b0, 10 - h);
    end
    apply_stimulus(1'b1, 1);
    apply_stimulus(1'b0, 12);
    for (int i = 0; i < 9; i++) expect_valid(10, i + 1, (i >= 3) ? 1 : 0, 0);
    check_output("sweep");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
